test_module_plant: RTL and testbench

TEST_MODULE_PLANT -- requirements
Module: test_module

---
 rtl/test_module_plant_pkg.sv | 40 ++++
 rtl/test_module_plant_delay_timer.sv | 30 +++
 rtl/test_module_plant.sv | 93 +++++++++
 tb/tb_test_module_plant.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/test_module_plant_pkg.sv
// Shared encodings for the elevator plant model: command and sensor codes
// plus the door state machine states.
package test_module_plant_pkg;

  typedef enum logic [1:0] {
    ENG_STOP  = 2'b00,
    ENG_UP    = 2'b01,
    ENG_DOWN  = 2'b10,
    ENG_STOP2 = 2'b11
  } engine_cmd_e;

  typedef enum logic [1:0] {
    DOOR_HOLD  = 2'b00,
    DOOR_OPEN  = 2'b01,
    DOOR_CLOSE = 2'b10,
    DOOR_HOLD2 = 2'b11
  } door_cmd_e;

  typedef enum logic [1:0] {
    SD_CLOSED = 2'b00,
    SD_OPEN   = 2'b01,
    SD_MOVING = 2'b10
  } door_sensor_e;

  typedef enum logic [1:0] {
    DS_CLOSED,
    DS_OPENING,
    DS_OPEN,
    DS_CLOSING
  } door_state_e;

  function automatic logic [1:0] door_sensor(input door_state_e s);
    case (s)
      DS_CLOSED: return SD_CLOSED;
      DS_OPEN:   return SD_OPEN;
      default:   return SD_MOVING;
    endcase
  endfunction

endpackage

// File: rtl/test_module_plant_delay_timer.sv
// Cycle counter with terminal-count strobe. A clear restarts the count; if the
// timer is also enabled that cycle, the cycle counts as the first one.
module delay_timer #(
  parameter int unsigned LIMIT = 10
) (
  input  logic i_clock,
  input  logic i_an_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_done
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_base;

  always_comb begin
    w_base = i_clear ? '0 : r_cnt;
    o_done = i_enable && (w_base == LAST);
  end

  always_ff @(posedge i_clock or posedge i_an_reset) begin
    if (i_an_reset)     r_cnt <= '0;
    else if (i_enable)  r_cnt <= o_done ? '0 : w_base + 1'b1;
    else if (i_clear)   r_cnt <= '0;
  end

endmodule

// File: rtl/test_module_plant.sv
// Elevator car and door plant: takes controller commands, reports door state
// and one-cycle floor-arrival pulses.
module test_module_plant
  import test_module_plant_pkg::*;
#(
  parameter int unsigned DELAY_ENGINE = 10,
  parameter int unsigned DELAY_DOOR   = 10,
  parameter int unsigned FLOORS       = 8
) (
  input  logic       clock,
  input  logic       an_reset,
  input  logic [1:0] engine,
  input  logic [1:0] door,
  output logic [1:0] sensor_door,
  output logic       sensor_up,
  output logic       sensor_down
);

  localparam int unsigned FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam logic [FW-1:0] TOP = FW'(FLOORS - 1);

  door_state_e r_state, w_state_next;
  door_cmd_e   w_door_cmd;
  logic        w_reverse, w_door_moving, w_door_done;

  logic [FW-1:0] r_floor;
  logic          r_was_up, w_up, w_down, w_travel, w_eng_done;
  logic [1:0]    r_sensor_door;
  logic          r_up, r_down;

  assign w_door_cmd    = door_cmd_e'(door);
  assign w_door_moving = (r_state == DS_OPENING) || (r_state == DS_CLOSING);
  assign w_reverse     = ((r_state == DS_OPENING) && (w_door_cmd == DOOR_CLOSE)) ||
                         ((r_state == DS_CLOSING) && (w_door_cmd == DOOR_OPEN));

  // A reversal restarts the door timer without counting the reversal cycle.
  delay_timer #(.LIMIT(DELAY_DOOR)) u_door_timer (
    .i_clock    (clock),
    .i_an_reset (an_reset),
    .i_enable   (w_door_moving && !w_reverse),
    .i_clear    (!w_door_moving || w_reverse),
    .o_done     (w_door_done)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      DS_CLOSED:  if (w_door_cmd == DOOR_OPEN)  w_state_next = DS_OPENING;
      DS_OPEN:    if (w_door_cmd == DOOR_CLOSE) w_state_next = DS_CLOSING;
      DS_OPENING: if (w_reverse)                w_state_next = DS_CLOSING;
                  else if (w_door_done)         w_state_next = DS_OPEN;
      DS_CLOSING: if (w_reverse)                w_state_next = DS_OPENING;
                  else if (w_door_done)         w_state_next = DS_CLOSED;
    endcase
  end

  assign w_up     = (engine_cmd_e'(engine) == ENG_UP);
  assign w_down   = (engine_cmd_e'(engine) == ENG_DOWN);
  // Travel stops on the same edge that an open request is accepted.
  assign w_travel = ((w_up && (r_floor != TOP)) || (w_down && (r_floor != '0))) &&
                    (r_state == DS_CLOSED) && (w_state_next == DS_CLOSED);

  delay_timer #(.LIMIT(DELAY_ENGINE)) u_engine_timer (
    .i_clock    (clock),
    .i_an_reset (an_reset),
    .i_enable   (w_travel),
    .i_clear    (!w_travel || (w_up != r_was_up)),
    .o_done     (w_eng_done)
  );

  always_ff @(posedge clock or posedge an_reset) begin
    if (an_reset) begin
      r_state       <= DS_CLOSED;
      r_floor       <= '0;
      r_was_up      <= 1'b0;
      r_sensor_door <= SD_CLOSED;
      r_up          <= 1'b0;
      r_down        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_was_up      <= w_up;
      r_sensor_door <= door_sensor(w_state_next);
      r_up          <= w_eng_done && w_up;
      r_down        <= w_eng_done && w_down;
      if (w_eng_done) r_floor <= w_up ? r_floor + 1'b1 : r_floor - 1'b1;
    end
  end

  assign sensor_door = r_sensor_door;
  assign sensor_up   = r_up;
  assign sensor_down = r_down;

endmodule

// File: tb/tb_test_module_plant.sv
// Directed and random checks of the elevator plant against a cycle-level
// behavioural model of car position and door movement.
module tb_test_module_plant;

  localparam int unsigned DE = 10;
  localparam int unsigned DD = 10;
  localparam int unsigned NF = 8;

  logic       clock = 1'b0;
  logic       an_reset;
  logic [1:0] engine, door;
  logic [1:0] sensor_door;
  logic       sensor_up, sensor_down;

  int checks = 0;
  int errors = 0;

  // model: door 0=closed 1=opening 2=open 3=closing
  int         m_ds, m_dm, m_fl, m_prog;
  bit         m_prev_up;
  logic [1:0] m_sd;
  logic       m_su, m_sdn;

  test_module_plant #(
    .DELAY_ENGINE (DE),
    .DELAY_DOOR   (DD),
    .FLOORS       (NF)
  ) dut (
    .clock       (clock),
    .an_reset    (an_reset),
    .engine      (engine),
    .door        (door),
    .sensor_door (sensor_door),
    .sensor_up   (sensor_up),
    .sensor_down (sensor_down)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ds = 0; m_dm = 0; m_fl = 0; m_prog = 0; m_prev_up = 1'b0;
    m_sd = 2'b00; m_su = 1'b0; m_sdn = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] e, input logic [1:0] d);
    int nds;
    bit up, dn, travel;
    nds = m_ds;
    up  = (e == 2'b01);
    dn  = (e == 2'b10);
    case (m_ds)
      0: if (d == 2'b01) begin nds = 1; m_dm = 0; end
      2: if (d == 2'b10) begin nds = 3; m_dm = 0; end
      1: if (d == 2'b10) begin nds = 3; m_dm = 0; end
         else begin m_dm++; if (m_dm == DD) begin nds = 2; m_dm = 0; end end
      default: if (d == 2'b01) begin nds = 1; m_dm = 0; end
         else begin m_dm++; if (m_dm == DD) begin nds = 0; m_dm = 0; end end
    endcase
    travel = ((up && (m_fl < NF - 1)) || (dn && (m_fl > 0))) && (m_ds == 0) && (nds == 0);
    m_su = 1'b0; m_sdn = 1'b0;
    if (!travel) m_prog = 0;
    else begin
      if (up != m_prev_up) m_prog = 0;
      m_prog++;
      if (m_prog == DE) begin
        m_prog = 0;
        if (up) begin m_fl++; m_su = 1'b1; end
        else    begin m_fl--; m_sdn = 1'b1; end
      end
    end
    m_prev_up = up;
    m_ds = nds;
    m_sd = (nds == 0) ? 2'b00 : (nds == 2) ? 2'b01 : 2'b10;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".door"}, sensor_door, m_sd);
    chk({tag, ".up"},   {1'b0, sensor_up},   {1'b0, m_su});
    chk({tag, ".down"}, {1'b0, sensor_down}, {1'b0, m_sdn});
    chk({tag, ".excl"}, {1'b0, sensor_up & sensor_down}, 2'b00);
  endtask

  task automatic step(input logic [1:0] e, input logic [1:0] d, input string tag);
    engine = e;
    door   = d;
    @(posedge clock);
    model_edge(e, d);
    #1;
    compare_all(tag);
  endtask

  // Called at posedge+1: reset rises between edges and must act at once.
  task automatic reset_async(input string tag);
    #2 an_reset = 1'b1;
    #1;
    model_reset();
    chk({tag, ".imm_door"}, sensor_door, 2'b00);
    chk({tag, ".imm_up"},   {1'b0, sensor_up},   2'b00);
    chk({tag, ".imm_down"}, {1'b0, sensor_down}, 2'b00);
    @(posedge clock);
    #1;
    compare_all({tag, ".hold"});
    an_reset = 1'b0;
  endtask

  initial begin
    logic [1:0] e, d;
    an_reset = 1'b1; engine = 2'b00; door = 2'b00;
    model_reset();
    #2;
    chk("reset.door", sensor_door, 2'b00);
    chk("reset.up",   {1'b0, sensor_up},   2'b00);
    chk("reset.down", {1'b0, sensor_down}, 2'b00);
    @(posedge clock);
    #1;
    compare_all("reset_hold");
    an_reset = 1'b0;

    // continuous up: pulse every DE cycles
    for (int i = 1; i <= 60; i++) begin
      step(2'b01, 2'b00, "up60");
      chk("up60.pulse", {1'b0, sensor_up}, (i % 10 == 0) ? 2'b01 : 2'b00);
      chk("up60.nodown", {1'b0, sensor_down}, 2'b00);
    end
    for (int i = 1; i <= 10; i++) begin
      step(2'b01, 2'b00, "to_top");
      chk("to_top.pulse", {1'b0, sensor_up}, (i == 10) ? 2'b01 : 2'b00);
    end
    // at top floor: up ignored
    for (int i = 1; i <= 30; i++) begin
      step(2'b01, 2'b00, "top_hold");
      chk("top_hold.noup", {1'b0, sensor_up}, 2'b00);
    end
    for (int i = 1; i <= 10; i++) begin
      step(2'b10, 2'b00, "from_top");
      chk("from_top.pulse", {1'b0, sensor_down}, (i == 10) ? 2'b01 : 2'b00);
    end

    // door open then close
    for (int i = 1; i <= 11; i++) begin
      step(2'b00, (i == 1) ? 2'b01 : 2'b00, "door_open");
      chk("door_open.sd", sensor_door, (i <= 10) ? 2'b10 : 2'b01);
    end
    for (int i = 1; i <= 11; i++) begin
      step(2'b00, (i == 1) ? 2'b10 : 2'b00, "door_close");
      chk("door_close.sd", sensor_door, (i <= 10) ? 2'b10 : 2'b00);
    end

    // open request during travel stops the car
    for (int i = 1; i <= 5; i++) step(2'b01, 2'b00, "pre_open");
    for (int i = 1; i <= 20; i++) begin
      step(2'b01, (i == 1) ? 2'b01 : 2'b00, "open_travel");
      chk("open_travel.noup", {1'b0, sensor_up}, 2'b00);
      chk("open_travel.sd", sensor_door, (i <= 10) ? 2'b10 : 2'b01);
    end
    for (int i = 1; i <= 11; i++) step(2'b00, (i == 1) ? 2'b10 : 2'b00, "reclose");

    // reset mid-opening
    step(2'b00, 2'b01, "pre_rst_door");
    for (int i = 1; i <= 3; i++) step(2'b00, 2'b00, "pre_rst_door");
    chk("pre_rst_door.moving", sensor_door, 2'b10);
    reset_async("rst_door");

    // reset mid-travel, right after a pulse
    for (int i = 1; i <= 10; i++) step(2'b01, 2'b00, "pre_rst_trav");
    chk("pre_rst_trav.pulse", {1'b0, sensor_up}, 2'b01);
    for (int i = 1; i <= 4; i++) step(2'b01, 2'b00, "pre_rst_trav");
    reset_async("rst_trav");
    for (int i = 1; i <= 10; i++) begin
      step(2'b01, 2'b00, "post_rst");
      chk("post_rst.pulse", {1'b0, sensor_up}, (i == 10) ? 2'b01 : 2'b00);
    end

    // direction change discards partial travel
    for (int i = 1; i <= 7; i++) step(2'b01, 2'b00, "dirchg_up");
    for (int i = 1; i <= 10; i++) begin
      step(2'b10, 2'b00, "dirchg_dn");
      chk("dirchg_dn.pulse", {1'b0, sensor_down}, (i == 10) ? 2'b01 : 2'b00);
      chk("dirchg_dn.noup", {1'b0, sensor_up}, 2'b00);
    end

    // random traffic against the model
    e = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 14) == 0) e = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 499) == 0) reset_async("rnd_rst");
      else step(e, d, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
